core_overlap_ctrl: RTL and testbench
====================================

CORE_OVERLAP_CTRL -- requirements
Module: core_overlap_ctrl

Interface
REQ-001 Parameter PIX_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter SIZE_OF_PRSC_INPUT, default 4, pixels per core column; COL_W = PIX_WIDTH*SIZE_OF_PRSC_INPUT (32 by default).
REQ-003 Parameter NUM_COLUMNS, default 8, columns per block; CNT_W = clog2(NUM_COLUMNS+1).
REQ-004 Parameter TIMEOUT_CYCLES, default 16, watchdog limit in WAIT.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  pulse; begins one block.
REQ-008 core_valid_i  in  4  per-core column valid, bit k = core k.
REQ-009 core_data_0_i..core_data_3_i  in  COL_W each  core column data.
REQ-010 core_ready_o  out  4  per-core slot-empty; capture occurs when valid and ready are both high.
REQ-011 prsc_en_o  out  1  enable to the overlap processor.
REQ-012 prsc_valid_o  out  1  one-cycle issue pulse to the overlap processor.
REQ-013 prsc_data_0_o..prsc_data_3_o  out  COL_W each  registered slot contents.
REQ-014 prsc_valid_i  in  1  overlap processor result valid.
REQ-015 busy_o  out  1; done_o  out  1 pulse; col_cnt_o  out  CNT_W, columns completed; err_o  out  1, watchdog error.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, ISSUE, WAIT, DONE; encoding is free.
REQ-017 In IDLE, start_i SHALL move to COLLECT and clear col_cnt_o, all slot flags and err_o; start_i outside IDLE SHALL be ignored.
REQ-018 core_ready_o[k] SHALL be high only in COLLECT while slot k is empty; a handshake SHALL load slot k and set its flag at that edge.
REQ-019 Simultaneous handshakes on several cores in one cycle SHALL all be captured; core_valid_i with ready low SHALL be ignored and no data SHALL be overwritten.
REQ-020 COLLECT with all four flags set SHALL go to ISSUE at the next edge; prsc_valid_o SHALL be high for exactly the one cycle spent in ISSUE, i.e. 2 cycles after the last capture edge.
REQ-021 ISSUE SHALL always go to WAIT; prsc_data_*_o SHALL remain stable from ISSUE through WAIT.
REQ-022 In WAIT, prsc_valid_i SHALL increment col_cnt_o, clear all flags, and go to DONE if the new count equals NUM_COLUMNS, else to COLLECT.
REQ-023 prsc_valid_i in any state other than WAIT SHALL be ignored.
REQ-024 DONE SHALL assert done_o for exactly one cycle and then return to IDLE; col_cnt_o SHALL hold NUM_COLUMNS until the next start_i.
REQ-025 busy_o and prsc_en_o SHALL be high in every state except IDLE.
REQ-026 col_cnt_o SHALL never exceed NUM_COLUMNS and SHALL never wrap.

Reset
REQ-027 rst_i high at an edge SHALL force IDLE from any state, including mid-block, and clear slot flags, slot data, col_cnt_o, err_o and all outputs to 0.
REQ-028 No capture, issue or count update SHALL occur in a cycle where rst_i is sampled high.

Configuration
REQ-029 With macro OVERLAP_CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT; after TIMEOUT_CYCLES cycles without prsc_valid_i it SHALL set err_o, which is sticky until rst_i or an accepted start_i. The FSM SHALL go to IDLE without pulsing done_o.
REQ-030 Without OVERLAP_CTRL_TIMEOUT_EN, err_o SHALL be tied 0, no watchdog logic SHALL exist, and WAIT SHALL persist indefinitely.

Verification
REQ-031 Reset, start_i, then all four cores valid in the same cycle with data 0x11111111..0x44444444 -> prsc_valid_o 2 cycles later, prsc_data_k_o equal to the core k data; prsc_valid_i -> col_cnt_o=1.
REQ-032 Cores arrive staggered (core 2, then 0, then 3, then 1), and core 2 asserts valid again while its slot is full -> its first data is retained, ready_o[2]=0, one issue only.
REQ-033 8 columns complete -> done_o exactly one cycle, col_cnt_o=8, busy_o=0; a start_i during the block is ignored.
REQ-034 rst_i asserted in WAIT after 3 columns -> next cycle IDLE, col_cnt_o=0, prsc_valid_o=0, core_ready_o=0.
REQ-035 With OVERLAP_CTRL_TIMEOUT_EN and no prsc_valid_i for 16 cycles -> err_o=1, IDLE, no done_o; the next start_i clears err_o. Without the macro -> err_o stays 0 and the FSM stays in WAIT.
REQ-036 prsc_valid_i pulsed in COLLECT -> col_cnt_o unchanged and no state change.

Source files
------------

// File: rtl/core_overlap_ctrl_if.sv
// Handshake bundle between the core columns, the overlap controller and the
// overlap processor. The controller connects via the slave modport.
interface core_overlap_ctrl_if #(
    parameter int COL_W = 32
);
    logic [3:0]       core_valid_i;
    logic [COL_W-1:0] core_data_0_i;
    logic [COL_W-1:0] core_data_1_i;
    logic [COL_W-1:0] core_data_2_i;
    logic [COL_W-1:0] core_data_3_i;
    logic [3:0]       core_ready_o;
    logic             prsc_en_o;
    logic             prsc_valid_o;
    logic [COL_W-1:0] prsc_data_0_o;
    logic [COL_W-1:0] prsc_data_1_o;
    logic [COL_W-1:0] prsc_data_2_o;
    logic [COL_W-1:0] prsc_data_3_o;
    logic             prsc_valid_i;

    modport slave (
        input  core_valid_i,
        input  core_data_0_i,
        input  core_data_1_i,
        input  core_data_2_i,
        input  core_data_3_i,
        output core_ready_o,
        output prsc_en_o,
        output prsc_valid_o,
        output prsc_data_0_o,
        output prsc_data_1_o,
        output prsc_data_2_o,
        output prsc_data_3_o,
        input  prsc_valid_i
    );

    modport master (
        output core_valid_i,
        output core_data_0_i,
        output core_data_1_i,
        output core_data_2_i,
        output core_data_3_i,
        input  core_ready_o,
        input  prsc_en_o,
        input  prsc_valid_o,
        input  prsc_data_0_o,
        input  prsc_data_1_o,
        input  prsc_data_2_o,
        input  prsc_data_3_o,
        output prsc_valid_i
    );
endinterface

// File: rtl/core_overlap_ctrl.sv
// Collects one column from each of four cores, issues the set to the overlap
// processor and counts completed columns. OVERLAP_CTRL_TIMEOUT_EN adds a WAIT watchdog.
module core_overlap_ctrl #(
    parameter int PIX_WIDTH          = 8,
    parameter int SIZE_OF_PRSC_INPUT = 4,
    parameter int NUM_COLUMNS        = 8,
    parameter int TIMEOUT_CYCLES     = 16,
    localparam int COL_W             = PIX_WIDTH * SIZE_OF_PRSC_INPUT,
    localparam int CNT_W             = $clog2(NUM_COLUMNS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    core_overlap_ctrl_if.slave    bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      col_cnt_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        flags_reg;
    logic [3:0]        flags_next;
    logic [COL_W-1:0]  slot_reg [4];
    logic [COL_W-1:0]  core_data [4];
    logic [3:0]        capture;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_inc;
    logic              start_ok;
    logic              col_ack;
    logic              last_col;
    logic              timeout;

    assign core_data[0] = bus.core_data_0_i;
    assign core_data[1] = bus.core_data_1_i;
    assign core_data[2] = bus.core_data_2_i;
    assign core_data[3] = bus.core_data_3_i;

    assign start_ok = (state_reg == S_IDLE) && start_i;
    assign col_ack  = (state_reg == S_WAIT) && bus.prsc_valid_i;
    assign cnt_inc  = cnt_reg + 1'b1;
    assign last_col = (cnt_inc == CNT_W'(NUM_COLUMNS));

    // A slot accepts only while collecting and empty, so a full slot never gets overwritten.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_capture
            assign capture[gi] = (state_reg == S_COLLECT) && bus.core_valid_i[gi] && !flags_reg[gi];
        end
    endgenerate

    always_comb begin
        flags_next = flags_reg;
        if (start_ok || col_ack) begin
            flags_next = 4'b0000;
        end else begin
            flags_next = flags_reg | capture;
        end
    end

`ifdef OVERLAP_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_reg;
    logic            err_reg;

    assign timeout = (state_reg == S_WAIT) && !bus.prsc_valid_i
                     && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    // Counts WAIT cycles without a result; restarts from zero on every WAIT entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_reg != S_WAIT) || bus.prsc_valid_i) begin
            wd_reg <= '0;
        end else if (!timeout) begin
            wd_reg <= wd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            err_reg <= 1'b0;
        end else if (timeout) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_i) state_next = S_COLLECT;
            S_COLLECT: if (flags_reg == 4'b1111) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_WAIT;
            S_WAIT: begin
                if (bus.prsc_valid_i) begin
                    state_next = last_col ? S_DONE : S_COLLECT;
                end else if (timeout) begin
                    state_next = S_IDLE;
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_reg <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                slot_reg[k] <= '0;
            end
        end else begin
            flags_reg <= flags_next;
            for (int k = 0; k < 4; k++) begin
                if (capture[k] && !start_ok) begin
                    slot_reg[k] <= core_data[k];
                end
            end
        end
    end

    // Saturating guard keeps the count from ever passing NUM_COLUMNS.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            cnt_reg <= '0;
        end else if (col_ack && (cnt_reg < CNT_W'(NUM_COLUMNS))) begin
            cnt_reg <= cnt_inc;
        end
    end

    always_comb begin
        bus.core_ready_o = 4'b0000;
        bus.prsc_en_o    = 1'b0;
        bus.prsc_valid_o = 1'b0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        if (state_reg == S_COLLECT) bus.core_ready_o = ~flags_reg;
        if (state_reg != S_IDLE) begin
            bus.prsc_en_o = 1'b1;
            busy_o        = 1'b1;
        end
        if (state_reg == S_ISSUE) bus.prsc_valid_o = 1'b1;
        if (state_reg == S_DONE)  done_o = 1'b1;
    end

    assign bus.prsc_data_0_o = slot_reg[0];
    assign bus.prsc_data_1_o = slot_reg[1];
    assign bus.prsc_data_2_o = slot_reg[2];
    assign bus.prsc_data_3_o = slot_reg[3];
    assign col_cnt_o         = cnt_reg;

endmodule

// File: tb/tb_core_overlap_ctrl.sv
// Scoreboard bench for core_overlap_ctrl: the driver predicts issues and done
// pulses into queues, an independent monitor pops and compares them.
module tb_core_overlap_ctrl;
    localparam int PIX_WIDTH      = 8;
    localparam int SIZE           = 4;
    localparam int NUM_COLUMNS    = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int COL_W          = PIX_WIDTH * SIZE;
    localparam int CNT_W          = $clog2(NUM_COLUMNS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] col_cnt;

    core_overlap_ctrl_if #(.COL_W(COL_W)) bus ();

    core_overlap_ctrl #(
        .PIX_WIDTH          (PIX_WIDTH),
        .SIZE_OF_PRSC_INPUT (SIZE),
        .NUM_COLUMNS        (NUM_COLUMNS),
        .TIMEOUT_CYCLES     (TIMEOUT_CYCLES)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bus       (bus),
        .busy_o    (busy),
        .done_o    (done),
        .col_cnt_o (col_cnt),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [4*COL_W-1:0] data;
    } issue_t;

    issue_t           issue_q [$];
    int               done_q [$];
    int               checks = 0;
    int               errors = 0;

    // Reference model: first datum each core offers in a column, and the column count.
    logic [COL_W-1:0] slot_m [4];
    logic [3:0]       sent = 4'b0000;
    int               last_cap = 0;
    int               model_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4*COL_W-1:0] model_data();
        return {slot_m[3], slot_m[2], slot_m[1], slot_m[0]};
    endfunction

    function automatic logic [4*COL_W-1:0] dut_data();
        return {bus.prsc_data_3_o, bus.prsc_data_2_o, bus.prsc_data_1_o, bus.prsc_data_0_o};
    endfunction

    task automatic drive_cores(input logic [3:0] mask, input logic [4*COL_W-1:0] d);
        bus.core_valid_i  = mask;
        bus.core_data_0_i = d[0*COL_W +: COL_W];
        bus.core_data_1_i = d[1*COL_W +: COL_W];
        bus.core_data_2_i = d[2*COL_W +: COL_W];
        bus.core_data_3_i = d[3*COL_W +: COL_W];
    endtask

    // One COLLECT cycle: offer mask/data, optionally with stray start_i and prsc_valid_i.
    task automatic present(input logic [3:0] mask, input logic [4*COL_W-1:0] d, input bit stray);
        drive_cores(mask, d);
        bus.prsc_valid_i = stray;
        start            = stray;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                check($sformatf("ready_core%0d", k), 128'(bus.core_ready_o[k]), 128'(!sent[k]));
                if (!sent[k]) begin
                    sent[k]   = 1'b1;
                    slot_m[k] = d[k*COL_W +: COL_W];
                    last_cap  = cyc;
                end
            end
        end
        @(negedge clk);
        drive_cores(4'b0000, '0);
        bus.prsc_valid_i = 1'b0;
        start            = 1'b0;
        if (stray) begin
            check("stray_cnt", 128'(col_cnt), 128'(model_cnt));
            check("stray_busy", 128'(busy), 128'd1);
        end
    endtask

    task automatic rand_column();
        while (sent != 4'b1111) begin
            present(4'($urandom_range(0, 15)),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 4) == 0));
        end
    endtask

    // Expect the issue two cycles after the last capture; junk valids meanwhile must be ignored.
    task automatic expect_issue();
        issue_t e;
        e.cyc  = last_cap + 2;
        e.data = model_data();
        issue_q.push_back(e);
        while (cyc < last_cap + 3) begin
            drive_cores(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
        end
        drive_cores(4'b0000, '0);
    endtask

    task automatic ack(input int delay);
        while (cyc < last_cap + 3 + delay) begin
            drive_cores(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
        end
        drive_cores(4'b0000, '0);
        check("prsc_data_hold", dut_data(), model_data());
        bus.prsc_valid_i = 1'b1;
        model_cnt++;
        sent = 4'b0000;
        if (model_cnt == NUM_COLUMNS) done_q.push_back(cyc + 1);
        @(negedge clk);
        bus.prsc_valid_i = 1'b0;
        check("col_cnt", 128'(col_cnt), 128'(model_cnt));
    endtask

    task automatic start_block();
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        model_cnt = 0;
        sent      = 4'b0000;
        check("start_cnt", 128'(col_cnt), 128'd0);
        check("start_busy", 128'(busy), 128'd1);
        check("start_en", 128'(bus.prsc_en_o), 128'd1);
        check("start_err", 128'(err), 128'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = 0;
        sent      = 4'b0000;
    endtask

    task automatic check_idle(input string tag, input int cnt);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_en"}, 128'(bus.prsc_en_o), 128'd0);
        check({tag, "_cnt"}, 128'(col_cnt), 128'(cnt));
        check({tag, "_ready"}, 128'(bus.core_ready_o), 128'd0);
        check({tag, "_pvalid"}, 128'(bus.prsc_valid_o), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
    endtask

    // Monitor: every issue or done pulse the DUT shows must match a queued expectation.
    initial begin : monitor
        issue_t e;
        int     dc;
        forever begin
            @(negedge clk);
            if (bus.prsc_valid_o) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = issue_q.pop_front();
                    check("issue_cycle", 128'(cyc), 128'(e.cyc));
                    check("issue_data", dut_data(), e.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    dc = done_q.pop_front();
                    check("done_cycle", 128'(cyc), 128'(dc));
                    check("done_cnt", 128'(col_cnt), 128'(NUM_COLUMNS));
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin : driver
        int l;
        rst              = 1'b1;
        start            = 1'b0;
        bus.prsc_valid_i = 1'b0;
        drive_cores(4'b0000, '0);
        @(negedge clk);
        do_reset();
        check_idle("reset", 0);
        check("reset_err", 128'(err), 128'd0);
        check("reset_data", dut_data(), '0);

        // Block A: directed columns, then random ones up to a full block.
        start_block();
        present(4'b1111, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0);
        expect_issue();
        ack(0);
        present(4'b0100, {32'hA3, 32'hA2, 32'hA2A2A2A2, 32'hA0}, 1'b0);
        present(4'b0101, {32'hB3, 32'hB2, 32'hBADBAD02, 32'hB0B0B0B0}, 1'b1);
        present(4'b1100, {32'hC3C3C3C3, 32'hC2, 32'hBADBAD22, 32'hC0}, 1'b0);
        present(4'b0010, {32'hD3, 32'hD1D1D1D1, 32'hD2, 32'hD0}, 1'b0);
        expect_issue();
        ack(2);
        for (int c = 2; c < NUM_COLUMNS; c++) begin
            rand_column();
            expect_issue();
            ack($urandom_range(0, 4));
        end
        @(negedge clk);
        check_idle("after_done", NUM_COLUMNS);

        // Block B: reset while waiting on the third column.
        start_block();
        for (int c = 0; c < 3; c++) begin
            rand_column();
            expect_issue();
            if (c < 2) ack($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        sent = 4'b0000;
        check_idle("mid_reset", 0);
        check("mid_reset_data", dut_data(), '0);

        // Block C: result never arrives after the first column.
        start_block();
        rand_column();
        expect_issue();
        l = last_cap;
        while (cyc < l + 18) @(negedge clk);
        check("wd_pre_busy", 128'(busy), 128'd1);
        check("wd_pre_err", 128'(err), 128'd0);
        @(negedge clk);
`ifdef OVERLAP_CTRL_TIMEOUT_EN
        check("wd_err", 128'(err), 128'd1);
        check("wd_idle", 128'(busy), 128'd0);
        check("wd_cnt", 128'(col_cnt), 128'd1);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", 128'(err), 128'd1);
        start_block();
`else
        check("nowd_err", 128'(err), 128'd0);
        check("nowd_busy", 128'(busy), 128'd1);
        repeat (6) @(negedge clk);
        check("nowd_busy_late", 128'(busy), 128'd1);
        ack(0);
`endif
        do_reset();
        check_idle("final", 0);
        repeat (2) @(negedge clk);
        check("issue_q_empty", 128'(issue_q.size()), 128'd0);
        check("done_q_empty", 128'(done_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
